// File: rtl/sr_frame_sequencer.sv
// Serial-programming sequencer for the static/dynamic configuration chains:
// accepts a frame command, shifts it out bit-serially, strobes the latch and enforces settle gaps.
module sr_frame_sequencer #(
    parameter int STAT_WIDTH  = 88,
    parameter int DYN_WIDTH   = 16,
    parameter int PRE_CYCLES  = 8,
    parameter int POST_CYCLES = 20,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_stat,
    input  logic [STAT_WIDTH-1:0] cmd_data,
    input  logic                  repeat_en,
    input  logic                  abort,
    output logic                  sel_dyn,
    output logic                  sel_stat,
    output logic                  shift_en,
    output logic                  sr_data,
    output logic                  latch_dyn,
    output logic                  latch_stat,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [15:0]           frame_cnt,
    output logic [2:0]            dbg_state
);
    localparam int MAXC = (STAT_WIDTH > PRE_CYCLES)
                        ? ((STAT_WIDTH > POST_CYCLES) ? STAT_WIDTH : POST_CYCLES)
                        : ((PRE_CYCLES > POST_CYCLES) ? PRE_CYCLES : POST_CYCLES);
    localparam int CW = $clog2(MAXC + 1);
    localparam int IW = $clog2(STAT_WIDTH);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_LATCH, S_POST} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [STAT_WIDTH-1:0]   frame_q, frame_d;
    logic                    stat_q, stat_d;
    logic                    gap_q, gap_d;
    logic                    done_q, done_d;
    logic                    aborted_q, aborted_d;
    logic [15:0]             frame_cnt_q;
    logic                    frame_end;
    int                      cnt_i, frame_len, pre_len;
    logic [IW-1:0]           bit_idx;

    assign cnt_i     = {{(32-CW){1'b0}}, cnt_q};
    assign frame_len = stat_q ? STAT_WIDTH : DYN_WIDTH;
    // A repeated frame spends one extra PRE cycle so the done cycle doubles as its cycle 0.
    assign pre_len   = PRE_CYCLES + (gap_q ? 1 : 0);
    assign bit_idx   = MSB_FIRST ? IW'(frame_len - 1 - cnt_i) : IW'(cnt_i);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            frame_q     <= '0;
            stat_q      <= 1'b0;
            gap_q       <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            stat_q    <= stat_d;
            gap_q     <= gap_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            if (done_d) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    // Handshake: cmd_ready is high exactly in IDLE; a command is taken on the
    // rising edge where cmd_valid && cmd_ready, and nothing else is accepted until IDLE again.
    always_comb begin
        state_d   = state_q;
        frame_d   = frame_q;
        stat_d    = stat_q;
        gap_d     = gap_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        frame_end = 1'b0;
        if (abort && (state_q != S_IDLE)) begin
            state_d   = S_IDLE;
            aborted_d = 1'b1;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        stat_d  = cmd_stat;
                        frame_d = cmd_data;
                        gap_d   = 1'b0;
                        state_d = (PRE_CYCLES > 0) ? S_PRE : S_SHIFT;
                    end
                end
                S_PRE: begin
                    if (cnt_i == pre_len - 1) state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    if (cnt_i == frame_len - 1) state_d = S_LATCH;
                end
                S_LATCH: begin
                    if (POST_CYCLES == 0) frame_end = 1'b1;
                    else                  state_d   = S_POST;
                end
                S_POST: begin
                    if (cnt_i == POST_CYCLES - 1) frame_end = 1'b1;
                end
                default: state_d = S_IDLE;
            endcase
            if (frame_end) begin
                done_d = 1'b1;
                if (repeat_en && !stat_q) begin
                    state_d = S_PRE;
                    gap_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
        end
        cnt_d = ((state_d != state_q) || (state_q == S_IDLE)) ? '0 : cnt_q + CW'(1);
    end

    assign cmd_ready  = (state_q == S_IDLE);
    assign busy       = (state_q != S_IDLE);
    assign shift_en   = (state_q == S_SHIFT);
    assign sel_stat   = (state_q == S_SHIFT) && stat_q;
    assign sel_dyn    = (state_q == S_SHIFT) && !stat_q;
    assign sr_data    = (state_q == S_SHIFT) && frame_q[bit_idx];
    assign latch_stat = (state_q == S_LATCH) && stat_q;
    assign latch_dyn  = (state_q == S_LATCH) && !stat_q;
    assign done       = done_q;
    assign aborted    = aborted_q;
    assign frame_cnt  = frame_cnt_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_sr_frame_sequencer.sv
// Bench for sr_frame_sequencer: three builds (MSB-first defaults, LSB-first, zero gaps)
// checked cycle-exactly against an expected event queue per instance.
module tb_sr_frame_sequencer;
    localparam int SW = 88;
    localparam int DW = 16;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    logic          cmd_valid [3];
    logic          cmd_stat  [3];
    logic [SW-1:0] cmd_data  [3];
    logic          repeat_en [3];
    logic          abort     [3];
    logic          cmd_ready [3];
    logic          sel_dyn   [3];
    logic          sel_stat  [3];
    logic          shift_en  [3];
    logic          sr_data   [3];
    logic          latch_dyn [3];
    logic          latch_stat[3];
    logic          busy      [3];
    logic          done      [3];
    logic          aborted   [3];
    logic [15:0]   frame_cnt [3];
    logic [2:0]    dbg_state [3];

    sr_frame_sequencer #(.MSB_FIRST(1'b1)) u0 (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_stat(cmd_stat[0]), .cmd_data(cmd_data[0]), .repeat_en(repeat_en[0]), .abort(abort[0]),
        .sel_dyn(sel_dyn[0]), .sel_stat(sel_stat[0]), .shift_en(shift_en[0]), .sr_data(sr_data[0]),
        .latch_dyn(latch_dyn[0]), .latch_stat(latch_stat[0]), .busy(busy[0]), .done(done[0]),
        .aborted(aborted[0]), .frame_cnt(frame_cnt[0]), .dbg_state(dbg_state[0]));

    sr_frame_sequencer #(.MSB_FIRST(1'b0)) u1 (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_stat(cmd_stat[1]), .cmd_data(cmd_data[1]), .repeat_en(repeat_en[1]), .abort(abort[1]),
        .sel_dyn(sel_dyn[1]), .sel_stat(sel_stat[1]), .shift_en(shift_en[1]), .sr_data(sr_data[1]),
        .latch_dyn(latch_dyn[1]), .latch_stat(latch_stat[1]), .busy(busy[1]), .done(done[1]),
        .aborted(aborted[1]), .frame_cnt(frame_cnt[1]), .dbg_state(dbg_state[1]));

    sr_frame_sequencer #(.PRE_CYCLES(0), .POST_CYCLES(0), .MSB_FIRST(1'b1)) u2 (
        .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid[2]), .cmd_ready(cmd_ready[2]),
        .cmd_stat(cmd_stat[2]), .cmd_data(cmd_data[2]), .repeat_en(repeat_en[2]), .abort(abort[2]),
        .sel_dyn(sel_dyn[2]), .sel_stat(sel_stat[2]), .shift_en(shift_en[2]), .sr_data(sr_data[2]),
        .latch_dyn(latch_dyn[2]), .latch_stat(latch_stat[2]), .busy(busy[2]), .done(done[2]),
        .aborted(aborted[2]), .frame_cnt(frame_cnt[2]), .dbg_state(dbg_state[2]));

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    // Event word: {cycle[15:0], outs[7:0], frame_cnt[15:0]};
    // outs = {sel_stat, sel_dyn, shift_en, sr_data, latch_dyn, latch_stat, done, aborted}
    logic [39:0] exp_q[3][$];

    function automatic int p_of(int i); return (i == 2) ? 0 : 8;  endfunction
    function automatic int q_of(int i); return (i == 2) ? 0 : 20; endfunction
    function automatic bit m_of(int i); return (i == 1) ? 1'b0 : 1'b1; endfunction

    function automatic logic [7:0] outs_of(int i);
        return {sel_stat[i], sel_dyn[i], shift_en[i], sr_data[i],
                latch_dyn[i], latch_stat[i], done[i], aborted[i]};
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic monitor_step();
        logic [39:0] act, e;
        for (int i = 0; i < 3; i++) begin
            if (outs_of(i) != 8'h00) begin
                act = {16'(cyc), outs_of(i), frame_cnt[i]};
                if (exp_q[i].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut%0d_unexpected_event got=%h expected=none", i, act);
                end else begin
                    e = exp_q[i].pop_front();
                    check($sformatf("dut%0d_event", i), 64'(act), 64'(e));
                end
            end
        end
    endtask

    task automatic push_shifts(int i, int a, bit stat, logic [SW-1:0] data, int base, int nbits);
        int n, idx;
        n = stat ? SW : DW;
        for (int j = 0; j < nbits; j++) begin
            idx = m_of(i) ? (n - 1 - j) : j;
            exp_q[i].push_back({16'(a + p_of(i) + 1 + j), stat, !stat, 1'b1, data[idx], 4'b0000, 16'(base)});
        end
    endtask

    task automatic push_latch(int i, int a, bit stat, int base);
        int n;
        n = stat ? SW : DW;
        exp_q[i].push_back({16'(a + p_of(i) + n + 1), 4'b0000, !stat, stat, 2'b00, 16'(base)});
    endtask

    task automatic push_done(int i, int a, bit stat, int base);
        int n;
        n = stat ? SW : DW;
        exp_q[i].push_back({16'(a + p_of(i) + n + q_of(i) + 2), 8'b0000_0010, 16'(base + 1)});
    endtask

    task automatic push_frame(int i, int a, bit stat, logic [SW-1:0] data, int base);
        push_shifts(i, a, stat, data, base, stat ? SW : DW);
        push_latch(i, a, stat, base);
        push_done(i, a, stat, base);
    endtask

    // Called at a falling edge; returns the accept cycle with cmd_valid still high.
    task automatic accept(int i, bit stat, logic [SW-1:0] data, output int a);
        int n;
        cmd_stat[i]  = stat;
        cmd_data[i]  = data;
        cmd_valid[i] = 1'b1;
        n = 0;
        while (!cmd_ready[i] && n < 300) begin
            @(negedge CLK);
            n++;
        end
        if (!cmd_ready[i]) begin
            checks++;
            errors++;
            $display("FAIL dut%0d_accept_timeout got=ready0 expected=ready1", i);
        end
        a = cyc;
    endtask

    task automatic drop(int i);
        @(negedge CLK);
        cmd_valid[i] = 1'b0;
    endtask

    task automatic wait_until(int c);
        while (cyc < c) @(negedge CLK);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a, bad;
        logic [SW-1:0] pat;
        for (int i = 0; i < 3; i++) begin
            cmd_valid[i] = 1'b0; cmd_stat[i] = 1'b0; cmd_data[i] = '0;
            repeat_en[i] = 1'b0; abort[i] = 1'b0;
        end
        RST = 1'b1;
        fork
            forever begin
                @(negedge CLK);
                monitor_step();
            end
        join_none
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dut%0d_reset_ready", i), 64'(cmd_ready[i]), 64'd1);
            check($sformatf("dut%0d_reset_busy", i), 64'(busy[i]), 64'd0);
            check($sformatf("dut%0d_reset_cnt", i), 64'(frame_cnt[i]), 64'd0);
            check($sformatf("dut%0d_reset_outs", i), 64'(outs_of(i)), 64'd0);
        end

        // Dynamic 16'h1234 MSB first: shifts 9..24, latch 25, done 46.
        accept(0, 1'b0, 88'h1234, a);
        push_frame(0, a, 1'b0, 88'h1234, 0);
        drop(0);
        wait_until(a + 47);
        check("dyn_cnt", 64'(frame_cnt[0]), 64'd1);
        check("dyn_ready", 64'(cmd_ready[0]), 64'd1);

        // Auto-repeat of 16'h8001, dropped during the third frame.
        repeat_en[0] = 1'b1;
        accept(0, 1'b0, 88'h8001, a);
        for (int k = 0; k < 3; k++) push_frame(0, a + k * 46, 1'b0, 88'h8001, 1 + k);
        drop(0);
        bad = 0;
        while (cyc < a + 138) begin
            if (cmd_ready[0]) bad++;
            if (cyc == a + 102) repeat_en[0] = 1'b0;
            @(negedge CLK);
        end
        check("repeat_ready_low_cycles", 64'(bad), 64'd0);
        check("repeat_ready_after", 64'(cmd_ready[0]), 64'd1);
        check("repeat_cnt", 64'(frame_cnt[0]), 64'd4);

        // Abort on shift cycle 5.
        accept(0, 1'b0, 88'hBEEF, a);
        push_shifts(0, a, 1'b0, 88'hBEEF, 4, 6);
        exp_q[0].push_back({16'(a + 15), 8'b0000_0001, 16'd4});
        drop(0);
        wait_until(a + 14);
        abort[0] = 1'b1;
        @(negedge CLK);
        abort[0] = 1'b0;
        check("abort_ready", 64'(cmd_ready[0]), 64'd1);
        check("abort_cnt", 64'(frame_cnt[0]), 64'd4);
        wait_until(a + 20);
        accept(0, 1'b0, 88'h00FF, a);
        push_frame(0, a, 1'b0, 88'h00FF, 4);
        drop(0);
        wait_until(a + 47);
        check("post_abort_cnt", 64'(frame_cnt[0]), 64'd5);

        // Abort in the final POST cycle beats completion.
        accept(0, 1'b0, 88'h0F0F, a);
        push_shifts(0, a, 1'b0, 88'h0F0F, 5, 16);
        push_latch(0, a, 1'b0, 5);
        exp_q[0].push_back({16'(a + 46), 8'b0000_0001, 16'd5});
        drop(0);
        wait_until(a + 45);
        abort[0] = 1'b1;
        @(negedge CLK);
        abort[0] = 1'b0;
        check("late_abort_cnt", 64'(frame_cnt[0]), 64'd5);
        check("late_abort_ready", 64'(cmd_ready[0]), 64'd1);

        // Abort while idle does nothing.
        abort[0] = 1'b1;
        repeat (2) @(negedge CLK);
        abort[0] = 1'b0;
        check("idle_abort_ready", 64'(cmd_ready[0]), 64'd1);

        // cmd_valid held with changing data: second command taken only in the done cycle.
        accept(0, 1'b0, 88'hC3A5, a);
        push_frame(0, a, 1'b0, 88'hC3A5, 5);
        push_frame(0, a + 46, 1'b0, 88'h5A5A, 6);
        @(negedge CLK);
        cmd_data[0] = 88'h5A5A;
        bad = 0;
        while (cyc < a + 46) begin
            if (cmd_ready[0]) bad++;
            @(negedge CLK);
        end
        check("held_ready_low_cycles", 64'(bad), 64'd0);
        check("held_ready_done_cycle", 64'(cmd_ready[0]), 64'd1);
        drop(0);
        wait_until(a + 93);
        check("held_cnt", 64'(frame_cnt[0]), 64'd7);

        // Static 0xA5 pattern LSB first; repeat_en must be ignored.
        pat = {11{8'hA5}};
        repeat_en[1] = 1'b1;
        accept(1, 1'b1, pat, a);
        push_frame(1, a, 1'b1, pat, 0);
        drop(1);
        wait_until(a + 118);
        check("stat_ready_done_cycle", 64'(cmd_ready[1]), 64'd1);
        wait_until(a + 125);
        check("stat_cnt", 64'(frame_cnt[1]), 64'd1);
        check("stat_busy", 64'(busy[1]), 64'd0);
        repeat_en[1] = 1'b0;
        accept(1, 1'b0, 88'h1234, a);
        push_frame(1, a, 1'b0, 88'h1234, 1);
        drop(1);
        wait_until(a + 47);
        check("lsb_dyn_cnt", 64'(frame_cnt[1]), 64'd2);

        // Zero PRE/POST build: shift from cycle 1, latch N+1, done N+2.
        accept(2, 1'b0, 88'h1234, a);
        push_frame(2, a, 1'b0, 88'h1234, 0);
        drop(2);
        wait_until(a + 19);
        check("nogap_cnt", 64'(frame_cnt[2]), 64'd1);
        repeat_en[2] = 1'b1;
        accept(2, 1'b0, 88'hA001, a);
        push_frame(2, a, 1'b0, 88'hA001, 1);
        push_frame(2, a + 18, 1'b0, 88'hA001, 2);
        drop(2);
        wait_until(a + 23);
        repeat_en[2] = 1'b0;
        wait_until(a + 37);
        check("nogap_repeat_cnt", 64'(frame_cnt[2]), 64'd3);
        check("nogap_repeat_ready", 64'(cmd_ready[2]), 64'd1);
        pat = {11{8'h3C}};
        accept(2, 1'b1, pat, a);
        push_frame(2, a, 1'b1, pat, 3);
        drop(2);
        wait_until(a + 95);
        check("nogap_stat_cnt", 64'(frame_cnt[2]), 64'd4);

        for (int i = 0; i < 3; i++)
            check($sformatf("dut%0d_pending_events", i), 64'(exp_q[i].size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
